// File: rtl/uart_pkt_pkg.sv
// rtl/uart_pkt_pkg.sv - shared constants and state encoding for the UART command-frame decoder
package uart_pkt_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_RUN   = 8'h02;

    localparam int FRAME_LEN  = 8;
    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 18;

    // One state per frame byte plus ISSUE
    localparam int STATE_W = $clog2(FRAME_LEN + 1);

    typedef enum logic [STATE_W-1:0] {
        ST_HUNT,
        ST_CMD,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_D2,
        ST_D1,
        ST_D0,
        ST_CSUM,
        ST_ISSUE
    } state_t;

endpackage

// File: rtl/uart_pkt_timer.sv
// rtl/uart_pkt_timer.sv - saturating idle timer with clear, enable and terminal-count pulse
module uart_pkt_timer #(
    parameter int TIMEOUT_CLKS = 51000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int CNT_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CLKS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A clear in the terminal cycle wins over the expiry
    assign o_tc = i_en && !i_clr && (cnt_q == LAST);

endmodule

// File: rtl/uart_pkt_decoder.sv
// rtl/uart_pkt_decoder.sv - 8-byte command frame parser to write/run transactions; checksum enabled by UART_PKT_CSUM_EN
module uart_pkt_decoder
    import uart_pkt_pkg::*;
#(
    parameter int CLK_FREQ     = 51000000,
    parameter int TIMEOUT_CLKS = CLK_FREQ / 1000,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_data,
    input  logic              i_valid,
    output logic              o_wr_valid,
    input  logic              i_wr_ready,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_run,
    output logic              o_err_csum,
    output logic              o_err_timeout,
    output logic              o_err_frame,
    output logic              o_err_overrun,
    output logic              o_busy,
    output logic [15:0]       o_pkt_count
);

    state_t            state_q, state_d;
    logic              cmd_run_q, cmd_run_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wr_valid_q, wr_valid_d;
    logic              run_q, run_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_frame_q, err_frame_d;
    logic              err_overrun_q, err_overrun_d;
    logic [15:0]       pkt_count_q, pkt_count_d;
    logic              in_frame;
    logic              timeout_tc;
    logic              csum_ok;

    assign in_frame = (state_q != ST_HUNT) && (state_q != ST_ISSUE);

    uart_pkt_timer #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timer (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_clr  (i_valid),
        .i_en   (in_frame),
        .o_tc   (timeout_tc)
    );

`ifdef UART_PKT_CSUM_EN
    logic [7:0] sum_q, sum_d;
    logic       err_csum_q, err_csum_d;

    assign csum_ok    = (8'(sum_q + i_data) == 8'h00);
    assign o_err_csum = err_csum_q;
`else
    assign csum_ok    = 1'b1;
    assign o_err_csum = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        cmd_run_d     = cmd_run_q;
        addr_d        = addr_q;
        data_d        = data_q;
        wr_valid_d    = wr_valid_q;
        pkt_count_d   = pkt_count_q;
        run_d         = 1'b0;
        err_timeout_d = 1'b0;
        err_frame_d   = 1'b0;
        err_overrun_d = 1'b0;
`ifdef UART_PKT_CSUM_EN
        err_csum_d    = 1'b0;
        sum_d         = (i_valid && in_frame) ? 8'(sum_q + i_data) : sum_q;
`endif
        case (state_q)
            ST_HUNT: begin
                if (i_valid && (i_data == SYNC_BYTE)) begin
                    state_d = ST_CMD;
`ifdef UART_PKT_CSUM_EN
                    sum_d   = 8'h00;
`endif
                end
            end
            ST_ISSUE: begin
                if (i_valid) err_overrun_d = 1'b1;
                if (cmd_run_q || i_wr_ready) begin
                    wr_valid_d  = 1'b0;
                    state_d     = ST_HUNT;
                    pkt_count_d = pkt_count_q + 16'd1;
                end
            end
            default: begin
                if (i_valid) begin
                    case (state_q)
                        ST_CMD: begin
                            if ((i_data == CMD_WRITE) || (i_data == CMD_RUN)) begin
                                cmd_run_d = (i_data == CMD_RUN);
                                state_d   = ST_ADDR_H;
                            end else begin
                                err_frame_d = 1'b1;
                                state_d     = ST_HUNT;
                            end
                        end
                        ST_ADDR_H: begin
                            addr_d  = ADDR_W'({i_data[3:0], 8'h00});
                            state_d = ST_ADDR_L;
                        end
                        ST_ADDR_L: begin
                            addr_d  = addr_q | ADDR_W'(i_data);
                            state_d = ST_D2;
                        end
                        ST_D2: begin
                            data_d  = DATA_W'({i_data[1:0], 16'h0000});
                            state_d = ST_D1;
                        end
                        ST_D1: begin
                            data_d  = data_q | DATA_W'({i_data, 8'h00});
                            state_d = ST_D0;
                        end
                        ST_D0: begin
                            data_d  = data_q | DATA_W'(i_data);
                            state_d = ST_CSUM;
                        end
                        ST_CSUM: begin
                            if (csum_ok) begin
                                state_d    = ST_ISSUE;
                                run_d      = cmd_run_q;
                                wr_valid_d = !cmd_run_q;
                            end else begin
`ifdef UART_PKT_CSUM_EN
                                err_csum_d = 1'b1;
`endif
                                state_d    = ST_HUNT;
                            end
                        end
                        default: ;
                    endcase
                end else if (timeout_tc) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_HUNT;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_HUNT;
            cmd_run_q     <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            wr_valid_q    <= 1'b0;
            run_q         <= 1'b0;
            err_timeout_q <= 1'b0;
            err_frame_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            pkt_count_q   <= 16'h0000;
`ifdef UART_PKT_CSUM_EN
            sum_q         <= 8'h00;
            err_csum_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cmd_run_q     <= cmd_run_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            wr_valid_q    <= wr_valid_d;
            run_q         <= run_d;
            err_timeout_q <= err_timeout_d;
            err_frame_q   <= err_frame_d;
            err_overrun_q <= err_overrun_d;
            pkt_count_q   <= pkt_count_d;
`ifdef UART_PKT_CSUM_EN
            sum_q         <= sum_d;
            err_csum_q    <= err_csum_d;
`endif
        end
    end

    assign o_wr_valid    = wr_valid_q;
    assign o_wr_addr     = addr_q;
    assign o_wr_data     = data_q;
    assign o_run         = run_q;
    assign o_err_timeout = err_timeout_q;
    assign o_err_frame   = err_frame_q;
    assign o_err_overrun = err_overrun_q;
    assign o_busy        = (state_q != ST_HUNT);
    assign o_pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_uart_pkt_decoder.sv
// tb/tb_uart_pkt_decoder.sv - directed self-checking bench for uart_pkt_decoder
module tb_uart_pkt_decoder;

    localparam int T = 200;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        o_wr_valid;
    logic        i_wr_ready;
    logic [11:0] o_wr_addr;
    logic [17:0] o_wr_data;
    logic        o_run;
    logic        o_err_csum;
    logic        o_err_timeout;
    logic        o_err_frame;
    logic        o_err_overrun;
    logic        o_busy;
    logic [15:0] o_pkt_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    int waited;

    uart_pkt_decoder #(
        .CLK_FREQ    (51000000),
        .TIMEOUT_CLKS(T),
        .ADDR_W      (12),
        .DATA_W      (18)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_wr_valid   (o_wr_valid),
        .i_wr_ready   (i_wr_ready),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_run        (o_run),
        .o_err_csum   (o_err_csum),
        .o_err_timeout(o_err_timeout),
        .o_err_frame  (o_err_frame),
        .o_err_overrun(o_err_overrun),
        .o_busy       (o_busy),
        .o_pkt_count  (o_pkt_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge i_clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_data  = b;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [63:0] f);
        for (int i = 7; i >= 0; i--) send_byte(f[i*8 +: 8]);
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_data     = 8'h00;
        i_valid    = 1'b0;
        i_wr_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_busy", o_busy, 0);
        check("rst_wr_valid", o_wr_valid, 0);
        check("rst_addr", o_wr_addr, 0);
        check("rst_count", o_pkt_count, 0);
        check("rst_errs", {o_run, o_err_csum, o_err_timeout, o_err_frame, o_err_overrun}, 0);
        i_rst_n = 1'b1;
        tick();

        // Write frame
        send_frame(64'hA5_01_0F_FF_03_12_34_A8);
        sample();
        check("wr_valid", o_wr_valid, 1);
        check("wr_addr", o_wr_addr, 12'hFFF);
        check("wr_data", o_wr_data, 18'h31234);
        check("wr_count_pre", o_pkt_count, 0);
        sample();
        exp_cnt++;
        check("wr_valid_drop", o_wr_valid, 0);
        check("wr_count", o_pkt_count, exp_cnt);
        check("wr_busy_done", o_busy, 0);
        tick();

        // Run frame
        send_frame(64'hA5_02_00_40_00_00_00_BE);
        sample();
        check("run_pulse", o_run, 1);
        check("run_addr", o_wr_addr, 12'h040);
        check("run_no_wr", o_wr_valid, 0);
        sample();
        exp_cnt++;
        check("run_pulse_end", o_run, 0);
        check("run_count", o_pkt_count, exp_cnt);
        check("run_busy_done", o_busy, 0);
        tick();

        // Bad checksum
        send_frame(64'hA5_01_0F_FF_03_12_34_A9);
        sample();
`ifdef UART_PKT_CSUM_EN
        check("csum_err", o_err_csum, 1);
        check("csum_no_wr", o_wr_valid, 0);
        check("csum_busy", o_busy, 0);
`else
        check("csum_err_tied", o_err_csum, 0);
        check("csum_wr", o_wr_valid, 1);
        exp_cnt++;
`endif
        sample();
        check("csum_count", o_pkt_count, exp_cnt);
        check("csum_err_end", o_err_csum, 0);
        tick();

        // Unknown command
        send_byte(8'hA5);
        send_byte(8'h07);
        sample();
        check("frame_err", o_err_frame, 1);
        check("frame_busy", o_busy, 0);
        sample();
        check("frame_err_end", o_err_frame, 0);
        tick();

        // Garbage, then timeout
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        sample();
        check("garbage_busy", o_busy, 0);
        tick();
        send_byte(8'hA5);
        send_byte(8'h01);
        waited = 0;
        sample();
        while (!o_err_timeout && waited < 2 * T) begin
            sample();
            waited++;
        end
        check("timeout_latency", waited, T);
        check("timeout_busy", o_busy, 0);
        check("timeout_other_errs", {o_err_frame, o_err_overrun, o_err_csum}, 0);
        sample();
        check("timeout_end", o_err_timeout, 0);
        tick();

        // Byte arriving in the terminal-count cycle wins
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (T - 1) @(posedge i_clk);
        #1;
        send_byte(8'h0F);
        sample();
        check("tc_byte_no_timeout", o_err_timeout, 0);
        check("tc_byte_busy", o_busy, 1);
        tick();
        send_byte(8'hFF);
        send_byte(8'h03);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hA8);
        sample();
        check("tc_frame_wr", o_wr_valid, 1);
        check("tc_frame_addr", o_wr_addr, 12'hFFF);
        sample();
        exp_cnt++;
        check("tc_frame_count", o_pkt_count, exp_cnt);
        tick();

        // Backpressure with overrun
        i_wr_ready = 1'b0;
        send_frame(64'hA5_01_01_23_01_AB_CD_62);
        sample();
        check("bp_valid", o_wr_valid, 1);
        repeat (5) tick();
        send_byte(8'h55);
        sample();
        check("bp_overrun", o_err_overrun, 1);
        check("bp_hold_valid", o_wr_valid, 1);
        check("bp_hold_addr", o_wr_addr, 12'h123);
        check("bp_hold_data", o_wr_data, 18'h1ABCD);
        check("bp_count_hold", o_pkt_count, exp_cnt);
        sample();
        check("bp_overrun_end", o_err_overrun, 0);
        repeat (14) @(posedge i_clk);
        #1;
        check("bp_still_valid", o_wr_valid, 1);
        i_wr_ready = 1'b1;
        sample();
        check("bp_accept_cycle", o_wr_valid, 1);
        sample();
        exp_cnt++;
        check("bp_accepted", o_wr_valid, 0);
        check("bp_count", o_pkt_count, exp_cnt);
        sample();
        check("bp_count_once", o_pkt_count, exp_cnt);
        tick();

        // Asynchronous reset mid-frame
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h0F);
        send_byte(8'hFF);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_busy", o_busy, 0);
        check("arst_addr", o_wr_addr, 0);
        check("arst_count", o_pkt_count, 0);
        check("arst_outs", {o_wr_valid, o_run, o_err_timeout, o_err_frame, o_err_overrun}, 0);
        tick();
        i_rst_n = 1'b1;
        tick();
        send_frame(64'hA5_01_0F_FF_03_12_34_A8);
        sample();
        check("post_rst_valid", o_wr_valid, 1);
        check("post_rst_data", o_wr_data, 18'h31234);
        sample();
        check("post_rst_count", o_pkt_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_pkt_decoder.md
Name: uart_pkt_decoder

Overview:
Consumes the byte stream from the UART receiver (8-bit data plus a 1-cycle valid strobe) and parses fixed-length 8-byte command frames. It emits 18-bit memory-write transactions or a run request with a 12-bit address toward the machine core. The block enforces framing, inter-byte timeout and checksum, and flags every error with a 1-cycle pulse.

Parameters:
- CLK_FREQ, 51000000, input clock frequency in Hz (documentation/derivation only).
- TIMEOUT_CLKS, 51000, maximum idle clocks between bytes inside a frame before it is aborted (1 ms at the default clock).
- ADDR_W, 12, width of the address field.
- DATA_W, 18, width of the data word.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_data  in  8  received byte from the UART receiver.
- i_valid  in  1  1-cycle strobe; i_data is valid in that cycle.
- o_wr_valid  out  1  write transaction pending.
- i_wr_ready  in  1  core accepts the write when o_wr_valid and i_wr_ready are both high.
- o_wr_addr  out  ADDR_W  write or run address.
- o_wr_data  out  DATA_W  write data.
- o_run  out  1  1-cycle run request; start address on o_wr_addr.
- o_err_csum  out  1  1-cycle pulse: checksum mismatch.
- o_err_timeout  out  1  1-cycle pulse: frame aborted by timeout.
- o_err_frame  out  1  1-cycle pulse: unknown command byte.
- o_err_overrun  out  1  1-cycle pulse: byte dropped while a transaction is pending.
- o_busy  out  1  high in every state except HUNT.
- o_pkt_count  out  16  count of issued writes plus runs; wraps from 0xFFFF to 0.

Behaviour:
- Frame format: SYNC (0xA5), CMD, ADDR_H, ADDR_L, D2, D1, D0, CSUM.
  - Address: addr = {ADDR_H[3:0], ADDR_L}; ADDR_H[7:4] is ignored.
  - Data: data = {D2[1:0], D1, D0}; D2[7:2] is ignored.
  - Checksum rule: (CMD + ADDR_H + ADDR_L + D2 + D1 + D0 + CSUM) mod 256 == 0.
  - CMD 0x01 is WRITE; CMD 0x02 is RUN (data bytes are consumed and ignored).
- States: HUNT, CMD, ADDR_H, ADDR_L, D2, D1, D0, CSUM, ISSUE. Each i_valid byte advances one state.
- HUNT: bytes other than 0xA5 are silently discarded. 0xA5 moves to CMD and clears the running sum.
- CMD: 0x01 or 0x02 is stored and the FSM moves to ADDR_H. Any other value pulses o_err_frame and returns to HUNT.
- Inside a frame, 0xA5 is ordinary data; there is no mid-frame resync.
- CSUM state, byte accepted at cycle N:
  - Check passes: ISSUE is entered at N+1.
  - WRITE: o_wr_valid rises at N+1 with o_wr_addr and o_wr_data stable.
  - RUN: o_run pulses at N+1, o_wr_addr holds the address, then the FSM returns to HUNT at N+2.
  - Check fails: o_err_csum pulses at N+1, nothing is issued, and the FSM returns to HUNT.
- ISSUE (WRITE):
  - o_wr_valid, o_wr_addr and o_wr_data are held until the handshake completes.
  - In the cycle of o_wr_valid && i_wr_ready the transaction is accepted: o_wr_valid drops and the FSM is in HUNT on the next cycle.
  - Any i_valid while in ISSUE, including the accept cycle, is dropped and pulses o_err_overrun.
- o_pkt_count increments on the accept cycle of a write, or on the o_run cycle.
- Timeout:
  - The counter clears on every i_valid and counts only in states CMD through CSUM.
  - When it reaches TIMEOUT_CLKS-1, o_err_timeout pulses and the FSM returns to HUNT.
  - If i_valid arrives in the same cycle as the terminal count, the byte wins and no timeout occurs.
  - The counter saturates and does not count in HUNT or ISSUE.
- Reset values: every output is 0, the state is HUNT, and the counters are 0. Reset asserted mid-frame or mid-ISSUE drops the transaction immediately.
- At most one error pulse fires per cycle.

Optional Feature:
- Macro: UART_PKT_CSUM_EN.
- When defined: the checksum is verified as above and o_err_csum is live.
- When undefined: the CSUM byte is consumed but not checked, every complete frame issues, o_err_csum is tied to 0, and no sum logic is synthesized.

Decomposition:
- Shared package uart_pkt_pkg:
  - SYNC_BYTE (0xA5), CMD_WRITE (0x01), CMD_RUN (0x02).
  - Frame length constant (8).
  - State enum.
  - ADDR_W and DATA_W defaults.
- One sub-module, uart_pkt_timer:
  - Timeout counter with clear, enable and terminal-count pulse, parameterized by TIMEOUT_CLKS.
  - Reused by other serial front ends.

Test Plan:
- Write frame: send A5 01 0F FF 03 12 34 A8 with i_wr_ready=1.
  - o_wr_valid for 1 cycle, addr=0xFFF, data=18'h31234, o_pkt_count=1.
- Run frame: send A5 02 00 40 00 00 00 BE.
  - One o_run pulse, o_wr_addr=0x040, o_wr_valid stays 0.
- Bad checksum (CSUM_EN defined): repeat the write frame with CSUM=A9.
  - o_err_csum pulse, no o_wr_valid, count unchanged.
  - Without the macro, the same frame issues the write.
- Garbage and timeout: send 00 FF 5A (ignored), then A5 01 followed by TIMEOUT_CLKS idle clocks.
  - o_err_timeout pulse, FSM back in HUNT.
  - A following valid frame decodes correctly.
- Backpressure: hold i_wr_ready=0 for 20 cycles after the write frame and send one byte during the stall.
  - o_err_overrun pulse; o_wr_valid and its payload stay stable.
  - Raising i_wr_ready accepts the write once.
- Reset mid-frame: assert i_rst_n=0 asynchronously after ADDR_L.
  - All outputs are 0 immediately.
  - After release, a full write frame decodes with o_pkt_count=1.
